bcd_tick_counter: RTL
=====================

// Module: bcd_tick_counter
// PURPOSE
//   Multi-digit BCD event counter with start/stop/clear control. Consumes the one-cycle
//   tick pulse from the rate divider and drives per-digit 4-bit BCD values to the
//   bitsToHex decoders. Replaces the single-digit display counter for multi-HEX displays.
// PARAMETERS
//   NUM_DIGITS  4  number of BCD digits (1..6); digit 0 is least significant
//   SATURATE    0  0: wrap all-9s -> all-0s and keep running; 1: hold at all-9s, go PAUSE
// PORTS
//   clk     in   1             system clock (CLOCK_50 at top level)
//   reset   in   1             asynchronous, active-high reset
//   tick    in   1             count-enable pulse from rate divider, one clk wide
//   start   in   1             pulse: IDLE/PAUSE -> RUN
//   stop    in   1             pulse: RUN -> PAUSE
//   clear   in   1             pulse: any state -> IDLE, count zeroed
//   lap     in   1             BCD_LAP_EN only: freeze/release displayed value
//   digits  out  4*NUM_DIGITS  BCD digits, digit k at [4k+3:4k]
//   running out  1             1 while state == RUN
//   wrap    out  1             one-cycle pulse on rollover or on reaching saturation
//   frozen  out  1             BCD_LAP_EN only: 1 while display is frozen
// BEHAVIOUR
//   - Reset (async, active-high): state IDLE, count 0, digits 0, running 0, wrap 0,
//     lap register 0, frozen 0. Reset mid-count discards count, no wrap pulse.
//   - FSM states IDLE, RUN, PAUSE. Control priority per cycle: clear > stop > start.
//     IDLE: start -> RUN. RUN: stop -> PAUSE. PAUSE: start -> RUN (count retained).
//     clear in any state -> IDLE, count 0 on the next edge. Other pulses ignored.
//   - Increment: on a clk edge where registered state == RUN and tick == 1.
//     start+tick same cycle from IDLE/PAUSE: tick ignored (not yet RUN).
//     stop+tick same cycle in RUN: tick counted, then PAUSE.
//     clear+tick same cycle: clear wins, count 0.
//   - Digits: each 0..9; digit k increments when all lower digits are 9 (ripple carry
//     computed combinationally, updated in one edge). Values 10..15 never appear.
//   - Rollover (all digits 9, counting tick): SATURATE=0 -> all digits 0, stay RUN,
//     wrap=1 for exactly the following cycle. SATURATE=1 -> digits hold all-9s, state
//     -> PAUSE, wrap=1 for one cycle; further ticks ignored until clear.
//     start from saturated PAUSE -> RUN, next tick re-asserts wrap, count stays all-9s.
//   - Latency: digits/wrap/running registered; visible the cycle after the sampling edge.
//   - running is registered state decode: rises one cycle after start pulse.
// CONFIGURATION
//   BCD_LAP_EN defined: lap and frozen ports exist. lap in RUN or PAUSE with frozen=0
//     copies live count into lap register, frozen=1; digits show lap register while
//     counting continues. lap with frozen=1 -> frozen=0, digits show live count next
//     cycle. clear or reset -> frozen=0. lap in IDLE ignored. lap+clear: clear wins.
//   BCD_LAP_EN undefined: no lap/frozen ports, no lap register; digits = live count.
// TESTING
//   1. reset, start, 12 ticks -> digits=16'h0012, running=1, wrap never asserted.
//   2. preload to 9999 via 9999 ticks (NUM_DIGITS=4, SATURATE=0), 1 tick -> digits=0000,
//      wrap high exactly 1 cycle, running stays 1.
//   3. SATURATE=1 at 9999, 3 more ticks -> digits=9999, wrap 1 cycle, running=0.
//   4. count 0042, stop+tick same cycle -> 0043, PAUSE; 5 ticks -> 0043; start, tick -> 0044.
//   5. clear+tick+start same cycle at 0500 -> IDLE, digits=0000, running=0; assert reset
//      mid-RUN -> all outputs 0 immediately (async).
//   6. BCD_LAP_EN: at 0007 lap, 10 ticks -> digits=0007, frozen=1; lap -> digits=0017,
//      frozen=0; lap then clear -> frozen=0, digits=0000.

Source files
------------

// File: rtl/bcd_tick_if.sv
// Control/display bundle between the rate-divider side and bcd_tick_counter.
// BCD_LAP_EN adds the lap input and frozen output.
interface bcd_tick_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  logic          tick;
  logic          start;
  logic          stop;
  logic          clear;
  logic [DW-1:0] digits;
  logic          running;
  logic          wrap;
`ifdef BCD_LAP_EN
  logic          lap;
  logic          frozen;

  modport master (output tick, start, stop, clear, lap,
                  input  digits, running, wrap, frozen);
  modport slave  (input  tick, start, stop, clear, lap,
                  output digits, running, wrap, frozen);
`else
  modport master (output tick, start, stop, clear,
                  input  digits, running, wrap);
  modport slave  (input  tick, start, stop, clear,
                  output digits, running, wrap);
`endif
endinterface

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD event counter with IDLE/RUN/PAUSE control and optional wrap saturation.
// Optional lap/freeze display feature enabled by defining BCD_LAP_EN.
module bcd_tick_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  bcd_tick_if.slave  io
);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic          running_q, running_d;
  logic [DW-1:0] inc_val;
  logic          carry;
  logic          count_tick;
`ifdef BCD_LAP_EN
  logic [DW-1:0] lap_q, lap_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          frozen_q, frozen_d;
`endif

  // Ripple-carry BCD increment; carry out of the top digit means the count was all 9s.
  always_comb begin
    carry   = 1'b1;
    inc_val = count_q;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  assign count_tick = (state_q == S_RUN) && io.tick;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
`ifdef BCD_LAP_EN
    lap_d    = lap_q;
    frozen_d = frozen_q;
`endif
    if (io.clear) begin
      state_d = S_IDLE;
      count_d = '0;
`ifdef BCD_LAP_EN
      frozen_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE:  if (io.start) state_d = S_RUN;
        S_RUN:   if (io.stop)  state_d = S_PAUSE;
        S_PAUSE: if (io.start) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
      // A saturating counter parks at all-9s and drops to PAUSE.
      if (count_tick) begin
        wrap_d = carry;
        if (SATURATE && carry) begin
          state_d = S_PAUSE;
        end else begin
          count_d = inc_val;
        end
      end
`ifdef BCD_LAP_EN
      if (io.lap && (state_q != S_IDLE)) begin
        if (!frozen_q) begin
          lap_d    = count_q;
          frozen_d = 1'b1;
        end else begin
          frozen_d = 1'b0;
        end
      end
`endif
    end
    running_d = (state_d == S_RUN);
`ifdef BCD_LAP_EN
    disp_d = frozen_d ? lap_d : count_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
`ifdef BCD_LAP_EN
      lap_q     <= '0;
      disp_q    <= '0;
      frozen_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
`ifdef BCD_LAP_EN
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      frozen_q  <= frozen_d;
`endif
    end
  end

  assign io.running = running_q;
  assign io.wrap    = wrap_q;
`ifdef BCD_LAP_EN
  assign io.digits  = disp_q;
  assign io.frozen  = frozen_q;
`else
  assign io.digits  = count_q;
`endif
endmodule
